axicb_slv_wr_arbiter: RTL

- Slave-side write arbiter. Shares one slave AXI write port (AW, W, B) between MST_NB master-side write switches.
- AW requests are arbitrated round-robin. Each granted index is queued in a W-order FIFO, so W bursts are forwarded in AW-grant order.
- B responses are routed back to the originating master by ID-mask match.

---
 rtl/axicb_pkg.sv | 18 +
 rtl/axicb_scfifo.sv | 77 +++++++
 rtl/axicb_slv_wr_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared types and helpers for the slave-side write arbiter
// Contents: AW arbitration state enum and the requester-index width helper.
package axicb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } aw_state_t;

   // Bits needed to hold an index in 0..n-1, never less than 1.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// rtl/axicb_scfifo.sv - single-clock FIFO used to keep W bursts in AW-grant order
// Ports: aclk/aresetn (async, active-low), srst (sync, active-high),
//        push/data_in/full on the write side, pull/data_out/empty on the read side.
//        PASS_THRU=1 forwards data_in straight to data_out while empty.
module axicb_scfifo
   import axicb_pkg::*;
#(
   parameter int PASS_THRU  = 0,
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 3
)(
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  srst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  full,
   input  logic                  pull,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic                  bypass, do_push, do_pull;

   always_comb begin
      // A push into an empty pass-through FIFO that is pulled in the same
      // cycle never touches the storage.
      bypass   = (PASS_THRU != 0) && (count_q == '0) && push && pull;
      full     = (count_q == DEPTH_CNT);
      empty    = (count_q == '0) && !((PASS_THRU != 0) && push);
      data_out = ((PASS_THRU != 0) && (count_q == '0)) ? data_in : mem_q[rd_ptr_q];
      // Full + pull frees the head slot this cycle, so the push is accepted.
      do_push  = push && (!full || pull) && !bypass;
      do_pull  = pull && (count_q != '0) && !bypass;

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_in;
         wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (do_pull) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
      if (do_push && !do_pull) count_d = count_q + (ADDR_WIDTH+1)'(1);
      else if (!do_push && do_pull) count_d = count_q - (ADDR_WIDTH+1)'(1);
      if (srst) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge aclk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/axicb_slv_wr_arbiter.sv
// rtl/axicb_slv_wr_arbiter.sv - shares one slave AXI write port between MST_NB masters
// Ports: aclk/aresetn (async, active-low), srst (sync, active-high);
//        i_aw*/i_w*/i_b* per-master channels (payloads packed master 0 in the LSBs),
//        o_aw*/o_w*/o_b* the single slave-side write port.
//        AW is round-robin arbitrated, W follows AW-grant order, B is routed by ID tag.
module axicb_slv_wr_arbiter
   import axicb_pkg::*;
#(
   parameter int                   AXI_ID_W         = 8,
   parameter int                   AXI_ADDR_W       = 8,
   parameter int                   MST_NB           = 4,
   parameter logic [AXI_ID_W-1:0]  MST_ID_MASK_BITS = AXI_ID_W'('hF0),
   parameter logic [AXI_ID_W-1:0]  MST0_ID_MASK     = AXI_ID_W'('h10),
   parameter logic [AXI_ID_W-1:0]  MST1_ID_MASK     = AXI_ID_W'('h20),
   parameter logic [AXI_ID_W-1:0]  MST2_ID_MASK     = AXI_ID_W'('h30),
   parameter logic [AXI_ID_W-1:0]  MST3_ID_MASK     = AXI_ID_W'('h40),
   parameter int                   WFIFO_DEPTH_LOG2 = 3,
   parameter int                   AWCH_W           = 8,
   parameter int                   WCH_W            = 8,
   parameter int                   BCH_W            = 10
)(
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic                     srst,
   input  logic [MST_NB-1:0]        i_awvalid,
   output logic [MST_NB-1:0]        i_awready,
   input  logic [MST_NB*AWCH_W-1:0] i_awch,
   input  logic [MST_NB-1:0]        i_wvalid,
   output logic [MST_NB-1:0]        i_wready,
   input  logic [MST_NB-1:0]        i_wlast,
   input  logic [MST_NB*WCH_W-1:0]  i_wch,
   output logic [MST_NB-1:0]        i_bvalid,
   input  logic [MST_NB-1:0]        i_bready,
   output logic [MST_NB*BCH_W-1:0]  i_bch,
   output logic                     o_awvalid,
   input  logic                     o_awready,
   output logic [AWCH_W-1:0]        o_awch,
   output logic                     o_wvalid,
   input  logic                     o_wready,
   output logic                     o_wlast,
   output logic [WCH_W-1:0]         o_wch,
   input  logic                     o_bvalid,
   output logic                     o_bready,
   input  logic [BCH_W-1:0]         o_bch
);

   localparam int IDX_W = clog2(MST_NB);
   localparam logic [4*AXI_ID_W-1:0] MST_ID_MASKS =
      {MST3_ID_MASK, MST2_ID_MASK, MST1_ID_MASK, MST0_ID_MASK};

   aw_state_t        state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] rr_q, rr_d;
   logic [IDX_W-1:0] cand, pick;
   logic             found;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [IDX_W-1:0] fifo_head;
   logic             b_hit;

   // AW arbitration: decide in IDLE, present in GRANT, so a request seen in
   // cycle N reaches o_awvalid in cycle N+1 and the grant holds until the
   // slave accepts it.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      o_awvalid = 1'b0;
      o_awch    = i_awch[grant_q*AWCH_W +: AWCH_W];
      i_awready = '0;
      fifo_push = 1'b0;
      found     = 1'b0;
      pick      = '0;
      cand      = '0;
      case (state_q)
         IDLE: begin
            // First requester at or after the pointer, wrapping around.
            for (int i = 0; i < MST_NB; i++) begin
               cand = IDX_W'((int'(rr_q) + i) % MST_NB);
               if (!found && i_awvalid[cand]) begin
                  found = 1'b1;
                  pick  = cand;
               end
            end
            // No grant while the W-order FIFO cannot take the index.
            if (found && !fifo_full) begin
               grant_d = pick;
               state_d = GRANT;
            end
         end
         GRANT: begin
            o_awvalid          = 1'b1;
            i_awready[grant_q] = o_awready;
            if (o_awready) begin
               fifo_push = 1'b1;
               rr_d      = (grant_q == IDX_W'(MST_NB-1)) ? '0 : grant_q + IDX_W'(1);
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (srst) begin
         state_d = IDLE;
         grant_d = '0;
         rr_d    = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         grant_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
      end
   end

   axicb_scfifo #(
      .PASS_THRU  (0),
      .DATA_WIDTH (IDX_W),
      .ADDR_WIDTH (WFIFO_DEPTH_LOG2)
   ) u_wfifo (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .srst     (srst),
      .push     (fifo_push),
      .data_in  (grant_q),
      .full     (fifo_full),
      .pull     (fifo_pop),
      .data_out (fifo_head),
      .empty    (fifo_empty)
   );

   // W path: only the master at the FIFO head sees o_wready; the index is
   // retired on the last beat of its burst.
   always_comb begin
      o_wvalid = 1'b0;
      o_wlast  = 1'b0;
      o_wch    = '0;
      i_wready = '0;
      fifo_pop = 1'b0;
      if (!fifo_empty) begin
         o_wvalid            = i_wvalid[fifo_head];
         o_wlast             = i_wlast[fifo_head];
         o_wch               = i_wch[fifo_head*WCH_W +: WCH_W];
         i_wready[fifo_head] = o_wready;
         fifo_pop            = o_wvalid && o_wready && o_wlast;
      end
   end

   // B path: route by ID tag; responses with no owner are absorbed.
   always_comb begin
      b_hit    = 1'b0;
      i_bvalid = '0;
      o_bready = 1'b1;
      for (int k = 0; k < MST_NB; k++) begin
         if (!b_hit && ((o_bch[AXI_ID_W-1:0] & MST_ID_MASK_BITS) ==
                        MST_ID_MASKS[k*AXI_ID_W +: AXI_ID_W])) begin
            b_hit       = 1'b1;
            i_bvalid[k] = o_bvalid;
            o_bready    = i_bready[k];
         end
      end
   end

   assign i_bch = {MST_NB{o_bch}};

endmodule
